// File: rtl/counter_pkg.sv
// Shared constants and types for the up/down counter family.
// Optional saturation is enabled with the UPDOWN_SAT_EN macro.
package counter_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam int   DEF_WIDTH = 8;

    typedef enum logic {
        MODE_WRAP,
        MODE_SAT
    } mode_e;

endpackage

// File: rtl/counter_step_calc.sv
// Combinational next-count calculator for one up/down step.
// Uses WIDTH+1 bit intermediates so the range compare never truncates.
module counter_step_calc
    import counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int MAX   = 2**WIDTH - 1
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic [WIDTH-1:0] step_i,
    input  logic             dir_i,
    input  mode_e            mode_i,
    output logic [WIDTH-1:0] next_o,
    output logic             wrap_o,
    output logic             sat_o
);

    localparam logic [WIDTH:0] MAX_W = (WIDTH+1)'(MAX);
    localparam logic [WIDTH:0] MOD_W = MAX_W + (WIDTH+1)'(1);

    logic [WIDTH:0] cnt_w;
    logic [WIDTH:0] s_w;
    logic [WIDTH:0] sum_w;
    logic           sat_on;

    assign cnt_w  = {1'b0, count_i};
    assign s_w    = {1'b0, step_i};
    assign sum_w  = cnt_w + s_w;
    assign sat_on = (mode_i == MODE_SAT);

    // Next value, boundary-crossing and clamp flags for one step
    always_comb begin
        next_o = count_i;
        wrap_o = 1'b0;
        sat_o  = 1'b0;
        if (dir_i == DIR_UP) begin
            if (sum_w > MAX_W) begin
                if (sat_on) begin
                    next_o = WIDTH'(MAX_W);
                    sat_o  = 1'b1;
                end else begin
                    next_o = WIDTH'(sum_w - MOD_W);
                    wrap_o = 1'b1;
                end
            end else begin
                next_o = WIDTH'(sum_w);
            end
        end else begin
            if (s_w > cnt_w) begin
                if (sat_on) begin
                    next_o = '0;
                    sat_o  = 1'b1;
                end else begin
                    next_o = WIDTH'(MOD_W - s_w + cnt_w);
                    wrap_o = 1'b1;
                end
            end else begin
                next_o = WIDTH'(cnt_w - s_w);
            end
        end
    end

endmodule

// File: rtl/updown_counter_mod.sv
// Parametrised up/down counter with load, wrap pulse and sticky overflow.
// Define UPDOWN_SAT_EN to add the sat_mode port and saturating mode.
module updown_counter_mod
    import counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int MAX   = 2**WIDTH - 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             direction,
    input  logic [WIDTH-1:0] step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             ovf_clr,
`ifdef UPDOWN_SAT_EN
    input  logic             sat_mode,
`endif
    output logic [WIDTH-1:0] counter_out,
    output logic             wrap,
    output logic             ovf_sticky,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] MAX_N = WIDTH'(MAX);

    logic [WIDTH-1:0] count_q, count_d;
    logic             wrap_q, wrap_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] step_c;
    logic [WIDTH-1:0] load_c;
    logic [WIDTH-1:0] calc_next;
    logic             calc_wrap;
    logic             calc_sat;
    mode_e            mode;

    assign step_c = (step > MAX_N) ? MAX_N : step;
    assign load_c = (load_value > MAX_N) ? MAX_N : load_value;

`ifdef UPDOWN_SAT_EN
    assign mode = sat_mode ? MODE_SAT : MODE_WRAP;
`else
    assign mode = MODE_WRAP;
`endif

    counter_step_calc #(
        .WIDTH (WIDTH),
        .MAX   (MAX)
    ) u_calc (
        .count_i (count_q),
        .step_i  (step_c),
        .dir_i   (direction),
        .mode_i  (mode),
        .next_o  (calc_next),
        .wrap_o  (calc_wrap),
        .sat_o   (calc_sat)
    );

    // Load beats enable; overflow set beats ovf_clr; load leaves ovf alone
    always_comb begin
        count_d = count_q;
        wrap_d  = 1'b0;
        ovf_d   = ovf_q;
        if (load) begin
            count_d = load_c;
        end else if (enable) begin
            count_d = calc_next;
            wrap_d  = calc_wrap;
        end
        if (!load && enable && (calc_wrap || calc_sat)) begin
            ovf_d = 1'b1;
        end else if (ovf_clr) begin
            ovf_d = 1'b0;
        end
    end

    // State registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            wrap_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            wrap_q  <= wrap_d;
            ovf_q   <= ovf_d;
        end
    end

    assign counter_out = count_q;
    assign wrap        = wrap_q;
    assign ovf_sticky  = ovf_q;
    assign at_max      = (count_q == MAX_N);
    assign at_min      = (count_q == '0);

endmodule

// File: tb/tb_updown_counter_mod.sv
// Self-checking bench: two counters (MAX=9 and MAX=255) share stimulus
// and are compared against a behavioural model of the counting rules.
module tb_updown_counter_mod;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       dir = 1'b1;
    logic [7:0] st = 8'd0;
    logic       ld = 1'b0;
    logic [7:0] lv = 8'd0;
    logic       clr = 1'b0;
    logic       sm = 1'b0;

    logic [7:0] co [2];
    logic       wr [2];
    logic       ov [2];
    logic       amx [2];
    logic       amn [2];

    int mc [2];
    int mw [2];
    int mo [2];
    int mx [2] = '{9, 255};

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    updown_counter_mod #(.WIDTH(8), .MAX(9)) dut_a (
        .clk(clk), .rst(rst), .enable(en), .direction(dir),
        .step(st), .load(ld), .load_value(lv), .ovf_clr(clr),
`ifdef UPDOWN_SAT_EN
        .sat_mode(sm),
`endif
        .counter_out(co[0]), .wrap(wr[0]), .ovf_sticky(ov[0]),
        .at_max(amx[0]), .at_min(amn[0])
    );

    updown_counter_mod #(.WIDTH(8), .MAX(255)) dut_b (
        .clk(clk), .rst(rst), .enable(en), .direction(dir),
        .step(st), .load(ld), .load_value(lv), .ovf_clr(clr),
`ifdef UPDOWN_SAT_EN
        .sat_mode(sm),
`endif
        .counter_out(co[1]), .wrap(wr[1]), .ovf_sticky(ov[1]),
        .at_max(amx[1]), .at_min(amn[1])
    );

    function automatic logic [11:0] exp_vec(int k);
        return {8'(mc[k]), mw[k][0], mo[k][0],
                mc[k] == mx[k], mc[k] == 0};
    endfunction

    function automatic logic [11:0] act_vec(int k);
        return {co[k], wr[k], ov[k], amx[k], amn[k]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            mc[k] = 0; mw[k] = 0; mo[k] = 0;
        end
    endtask

    // Drive one cycle, advance the model, sample 1 time unit after the edge
    task automatic cycle(input bit e, input bit d, input int s,
                         input bit l, input int v, input bit c,
                         input bit sat);
        bit sat_eff;
        en = e; dir = d; st = 8'(s); ld = l; lv = 8'(v); clr = c; sm = sat;
`ifdef UPDOWN_SAT_EN
        sat_eff = sat;
`else
        sat_eff = 1'b0;
`endif
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            int ss, t;
            bit ev;
            ev = 1'b0;
            mw[k] = 0;
            if (l) begin
                mc[k] = (v > mx[k]) ? mx[k] : v;
            end else if (e) begin
                ss = (s > mx[k]) ? mx[k] : s;
                t = d ? mc[k] + ss : mc[k] - ss;
                if (t > mx[k] || t < 0) begin
                    ev = 1'b1;
                    if (sat_eff) begin
                        mc[k] = (t < 0) ? 0 : mx[k];
                    end else begin
                        mc[k] = (t < 0) ? t + mx[k] + 1 : t - (mx[k] + 1);
                        mw[k] = 1;
                    end
                end else begin
                    mc[k] = t;
                end
            end
            if (ev) mo[k] = 1;
            else if (c) mo[k] = 0;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (act_vec(k) !== 12'h001) begin
                n_fail++;
                $display("FAIL reset_state[%0d]: got %h expected 001", k, act_vec(k));
            end
        end
        rst = 1'b1;
    endtask

    task automatic test_up_wrap();
        cycle(0, 1, 0, 1, 6, 0, 0);
        cycle(1, 1, 3, 0, 0, 0, 0);
        n_tests++;
        if (co[0] !== 8'd9 || amx[0] !== 1'b1 || wr[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL up_wrap_at9: got cnt=%0d atmax=%b wrap=%b expected 9 1 0",
                     co[0], amx[0], wr[0]);
        end
        cycle(1, 1, 3, 0, 0, 0, 0);
        n_tests++;
        if (co[0] !== 8'd2 || wr[0] !== 1'b1 || ov[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL up_wrap_to2: got cnt=%0d wrap=%b ovf=%b expected 2 1 1",
                     co[0], wr[0], ov[0]);
        end
        cycle(0, 1, 3, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (act_vec(k) !== exp_vec(k)) begin
                n_fail++;
                $display("FAIL up_wrap_after[%0d]: got %h expected %h",
                         k, act_vec(k), exp_vec(k));
            end
        end
    endtask

    task automatic test_down_wrap();
        cycle(0, 0, 0, 1, 0, 1, 0);
        cycle(1, 0, 1, 0, 0, 0, 0);
        n_tests++;
        if (co[1] !== 8'd255 || wr[1] !== 1'b1 || ov[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL down_wrap_255: got cnt=%0d wrap=%b ovf=%b expected 255 1 1",
                     co[1], wr[1], ov[1]);
        end
        cycle(0, 0, 1, 0, 0, 1, 0);
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (ov[k] !== 1'b0 || act_vec(k) !== exp_vec(k)) begin
                n_fail++;
                $display("FAIL down_wrap_clr[%0d]: got %h expected %h",
                         k, act_vec(k), exp_vec(k));
            end
        end
    endtask

    task automatic test_load_clamp();
        cycle(1, 1, 5, 1, 200, 0, 0);
        n_tests++;
        if (co[0] !== 8'd9 || wr[0] !== 1'b0 || co[1] !== 8'd200) begin
            n_fail++;
            $display("FAIL load_clamp: got a=%0d wrap=%b b=%0d expected 9 0 200",
                     co[0], wr[0], co[1]);
        end
    endtask

    task automatic test_hold();
        for (int i = 0; i < 5; i++) begin
            cycle(0, i[0], 7, 0, 0, 0, 0);
            n_tests++;
            if (co[0] !== 8'd9 || co[1] !== 8'd200 || wr[0] || wr[1]) begin
                n_fail++;
                $display("FAIL hold_%0d: got a=%0d b=%0d expected 9 200", i, co[0], co[1]);
            end
        end
        cycle(1, 1, 0, 0, 0, 0, 0);
        n_tests++;
        if (co[0] !== 8'd9 || co[1] !== 8'd200 || wr[0] || wr[1]) begin
            n_fail++;
            $display("FAIL zero_step: got a=%0d b=%0d expected 9 200", co[0], co[1]);
        end
        cycle(1, 1, 1, 0, 0, 1, 0);
        n_tests++;
        if (co[0] !== 8'd0 || wr[0] !== 1'b1 || ov[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL set_beats_clr: got cnt=%0d wrap=%b ovf=%b expected 0 1 1",
                     co[0], wr[0], ov[0]);
        end
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (act_vec(k) !== exp_vec(k)) begin
                n_fail++;
                $display("FAIL hold_model[%0d]: got %h expected %h",
                         k, act_vec(k), exp_vec(k));
            end
        end
    endtask

`ifdef UPDOWN_SAT_EN
    task automatic test_sat();
        cycle(0, 1, 0, 1, 250, 1, 1);
        cycle(1, 1, 10, 0, 0, 0, 1);
        n_tests++;
        if (co[1] !== 8'd255 || wr[1] !== 1'b0 || ov[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_up: got cnt=%0d wrap=%b ovf=%b expected 255 0 1",
                     co[1], wr[1], ov[1]);
        end
        cycle(0, 0, 0, 1, 5, 1, 1);
        cycle(1, 0, 10, 0, 0, 0, 1);
        n_tests++;
        if (co[1] !== 8'd0 || wr[1] !== 1'b0 || ov[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL sat_down: got cnt=%0d wrap=%b ovf=%b expected 0 0 1",
                     co[1], wr[1], ov[1]);
        end
        cycle(0, 0, 0, 1, 245, 1, 1);
        cycle(1, 1, 10, 0, 0, 0, 1);
        n_tests++;
        if (co[1] !== 8'd255 || ov[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL sat_exact: got cnt=%0d ovf=%b expected 255 0", co[1], ov[1]);
        end
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            int s;
            s = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 12))
                                             : int'($urandom_range(0, 255));
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0, s,
                  $urandom_range(0, 9) == 0, int'($urandom_range(0, 255)),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 1) != 0);
            for (int k = 0; k < 2; k++) begin
                n_tests++;
                if (act_vec(k) !== exp_vec(k)) begin
                    n_fail++;
                    $display("FAIL random_%0d[%0d]: got %h expected %h",
                             i, k, act_vec(k), exp_vec(k));
                end
            end
        end
    endtask

    task automatic test_async_reset();
        cycle(0, 1, 0, 1, 37, 0, 0);
        cycle(1, 0, 1, 0, 0, 0, 0);
        cycle(1, 1, 1, 0, 0, 0, 0);
        n_tests++;
        if (co[1] !== 8'd37) begin
            n_fail++;
            $display("FAIL pre_reset: got %0d expected 37", co[1]);
        end
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (act_vec(k) !== 12'h001) begin
                n_fail++;
                $display("FAIL async_reset[%0d]: got %h expected 001", k, act_vec(k));
            end
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        cycle(0, 1, 0, 0, 0, 0, 0);
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (act_vec(k) !== 12'h001) begin
                n_fail++;
                $display("FAIL post_reset[%0d]: got %h expected 001", k, act_vec(k));
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_wrap();
        test_down_wrap();
        test_load_clamp();
        test_hold();
`ifdef UPDOWN_SAT_EN
        test_sat();
`endif
        test_random();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
